reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file for the core: NUM_READ combinational read ports,
//  NUM_WRITE clocked write ports, optional write-to-read bypass and a per-register pending

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/reg_file_mp.sv | 80 ++++++++
 tb/tb_reg_file_mp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register file widths and address-width helper
package rf_pkg;
   localparam int RF_XLEN     = 32;
   localparam int RF_NUM_REGS = 32;

   // Address width for a register count; a single-bit address is the floor.
   function automatic int rf_aw_f(input int num_regs);
      return (num_regs > 2) ? $clog2(num_regs) : 1;
   endfunction

   localparam int RF_AW = rf_aw_f(RF_NUM_REGS);
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with reserve/clear and busy lookup
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NUM_REGS  = RF_NUM_REGS,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 1,
   parameter int BYPASS    = 1,
   parameter int AW        = rf_aw_f(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_READ*AW-1:0]  read_reg,
   output logic [NUM_READ-1:0]     read_busy,
   input  logic [NUM_WRITE-1:0]    clr_en,
   input  logic [NUM_WRITE*AW-1:0] clr_reg,
   input  logic                    set_en,
   input  logic [AW-1:0]           set_reg
);
   logic [NUM_REGS-1:0] pending;

   // The reservation is applied last so it wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (clr_en[w]) pending[clr_reg[w*AW +: AW]] <= 1'b0;
         end
         if (set_en) pending[set_reg] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
      logic [AW-1:0] addr;
      logic          hit;
      logic          busy;

      assign addr = read_reg[i*AW +: AW];

      always_comb begin
         hit  = 1'b0;
         busy = pending[addr];
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (clr_en[w] && clr_reg[w*AW +: AW] == addr) hit = 1'b1;
         end
         if (BYPASS != 0 && hit && !(set_en && set_reg == addr)) busy = 1'b0;
      end

      assign read_busy[i] = busy;
   end
endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with bypass and pending scoreboard
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int XLEN      = RF_XLEN,
   parameter int NUM_REGS  = RF_NUM_REGS,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 1,
   parameter int BYPASS    = 1,
   parameter int ZERO_REG  = 1,
   localparam int AW       = rf_aw_f(NUM_REGS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_READ*AW-1:0]    read_reg,
   output logic [NUM_READ*XLEN-1:0]  read_data,
   output logic [NUM_READ-1:0]       read_busy,
   input  logic [NUM_WRITE-1:0]      write_en,
   input  logic [NUM_WRITE*AW-1:0]   write_reg,
   input  logic [NUM_WRITE*XLEN-1:0] write_data,
   input  logic                      rsv_en,
   input  logic [AW-1:0]             rsv_reg
);
   logic [XLEN-1:0]      regs [NUM_REGS];
   logic [NUM_WRITE-1:0] wr_ok;
   logic                 rsv_ok;

   // Hardwired-zero register swallows writes and reservations before anything sees them.
   for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wr
      assign wr_ok[k] = write_en[k] && !(ZERO_REG != 0 && write_reg[k*AW +: AW] == '0);
   end
   assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_reg == '0);

   // Later write ports overwrite earlier ones, giving the highest index priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_ok[w]) regs[write_reg[w*AW +: AW]] <= write_data[w*XLEN +: XLEN];
         end
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] val;

      assign addr = read_reg[i*AW +: AW];

      always_comb begin
         val = regs[addr];
         if (BYPASS != 0) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
               if (wr_ok[w] && write_reg[w*AW +: AW] == addr) val = write_data[w*XLEN +: XLEN];
            end
         end
         if (ZERO_REG != 0 && addr == '0) val = '0;
      end

      assign read_data[i*XLEN +: XLEN] = val;
   end

   rf_scoreboard #(
      .NUM_REGS  (NUM_REGS),
      .NUM_READ  (NUM_READ),
      .NUM_WRITE (NUM_WRITE),
      .BYPASS    (BYPASS),
      .AW        (AW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .read_reg  (read_reg),
      .read_busy (read_busy),
      .clr_en    (wr_ok),
      .clr_reg   (write_reg),
      .set_en    (rsv_ok),
      .set_reg   (rsv_reg)
   );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp in two configurations
module tb_reg_file_mp;
   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  read_reg;
   logic [1:0]  write_en;
   logic [9:0]  write_reg;
   logic [63:0] write_data;
   logic        rsv_en;
   logic [4:0]  rsv_reg;

   logic [63:0] rd_a, rd_b;
   logic [1:0]  busy_a, busy_b;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   logic [31:0] m_a [32];
   logic [31:0] m_b [32];
   bit          p_a [32];
   bit          p_b [32];

   always #5 clk = ~clk;

   // A: two write ports, bypass, hardwired r0.  B: one write port, no bypass, plain r0.
   reg_file_mp #(.NUM_WRITE(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk(clk), .reset(reset), .read_reg(read_reg), .read_data(rd_a), .read_busy(busy_a),
      .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
      .rsv_en(rsv_en), .rsv_reg(rsv_reg));

   reg_file_mp #(.NUM_WRITE(1), .BYPASS(0), .ZERO_REG(0)) dut_b (
      .clk(clk), .reset(reset), .read_reg(read_reg), .read_data(rd_b), .read_busy(busy_b),
      .write_en(write_en[0]), .write_reg(write_reg[4:0]), .write_data(write_data[31:0]),
      .rsv_en(rsv_en), .rsv_reg(rsv_reg));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd_a(input int p);
      logic [4:0]  addr = read_reg[p*5 +: 5];
      logic [31:0] v;
      if (addr == 5'd0) return 32'd0;
      v = m_a[addr];
      for (int k = 0; k < 2; k++)
         if (write_en[k] && write_reg[k*5 +: 5] == addr) v = write_data[k*32 +: 32];
      return v;
   endfunction

   function automatic logic exp_busy_a(input int p);
      logic [4:0] addr = read_reg[p*5 +: 5];
      bit hit = 1'b0;
      if (addr == 5'd0) return 1'b0;
      for (int k = 0; k < 2; k++)
         if (write_en[k] && write_reg[k*5 +: 5] == addr) hit = 1'b1;
      if (hit && !(rsv_en && rsv_reg == addr)) return 1'b0;
      return p_a[addr];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) begin
            m_a[r] = '0; m_b[r] = '0; p_a[r] = 1'b0; p_b[r] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (write_en[k] && write_reg[k*5 +: 5] != 5'd0) begin
               m_a[write_reg[k*5 +: 5]] = write_data[k*32 +: 32];
               p_a[write_reg[k*5 +: 5]] = 1'b0;
            end
         end
         if (rsv_en && rsv_reg != 5'd0) p_a[rsv_reg] = 1'b1;
         if (write_en[0]) begin
            m_b[write_reg[4:0]] = write_data[31:0];
            p_b[write_reg[4:0]] = 1'b0;
         end
         if (rsv_en) p_b[rsv_reg] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("model_rd_a%0d", p), rd_a[p*32 +: 32], exp_rd_a(p));
            chk($sformatf("model_busy_a%0d", p), {31'd0, busy_a[p]}, {31'd0, exp_busy_a(p)});
            chk($sformatf("model_rd_b%0d", p), rd_b[p*32 +: 32], m_b[read_reg[p*5 +: 5]]);
            chk($sformatf("model_busy_b%0d", p), {31'd0, busy_b[p]}, {31'd0, p_b[read_reg[p*5 +: 5]]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write_en = '0; write_reg = '0; write_data = '0; rsv_en = 1'b0; rsv_reg = '0;
   endtask

   task automatic wr(input int p, input logic [4:0] r, input logic [31:0] d);
      write_en[p] = 1'b1;
      write_reg[p*5 +: 5] = r;
      write_data[p*32 +: 32] = d;
   endtask

   initial begin
      reset = 1'b1; read_reg = '0; idle();
      tick(); tick();
      reset = 1'b0; chk_on = 1'b1;

      // reset state on every register
      for (int r = 0; r < 32; r++) begin
         read_reg = {5'(31 - r), 5'(r)};
         @(negedge clk);
         if (r == 17) begin
            chk("rst_rd_a", rd_a[31:0], 32'd0);
            chk("rst_busy_b", {30'd0, busy_b}, 32'd0);
         end
         tick();
      end

      // write r5 with same-cycle read
      read_reg = {5'd0, 5'd5}; wr(0, 5'd5, 32'hDEADBEEF);
      @(negedge clk);
      chk("byp_r5_a", rd_a[31:0], 32'hDEADBEEF);
      chk("nobyp_r5_b", rd_b[31:0], 32'd0);
      tick(); idle();
      @(negedge clk);
      chk("arr_r5_a", rd_a[31:0], 32'hDEADBEEF);
      chk("arr_r5_b", rd_b[31:0], 32'hDEADBEEF);
      tick();

      // write and reserve r0
      read_reg = {5'd0, 5'd0}; wr(0, 5'd0, 32'h1234); rsv_en = 1'b1; rsv_reg = 5'd0;
      @(negedge clk);
      chk("r0_rd_a_now", rd_a[31:0], 32'd0);
      chk("r0_busy_a_now", {31'd0, busy_a[0]}, 32'd0);
      tick(); idle();
      @(negedge clk);
      chk("r0_rd_a_after", rd_a[31:0], 32'd0);
      chk("r0_busy_a_after", {31'd0, busy_a[0]}, 32'd0);
      chk("r0_rd_b_after", rd_b[31:0], 32'h1234);
      chk("r0_busy_b_after", {31'd0, busy_b[0]}, 32'd1);
      tick();

      // both write ports on r7
      read_reg = {5'd7, 5'd7}; wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
      @(negedge clk);
      chk("prio_byp_a", rd_a[63:32], 32'h22);
      tick(); idle();
      @(negedge clk);
      chk("prio_arr_a", rd_a[31:0], 32'h22);
      chk("prio_arr_b", rd_b[31:0], 32'h11);
      tick();

      // reservation life-cycle on r9
      read_reg = {5'd9, 5'd9}; rsv_en = 1'b1; rsv_reg = 5'd9;
      tick(); idle();
      @(negedge clk);
      chk("rsv_busy_a", {31'd0, busy_a[0]}, 32'd1);
      tick();
      wr(0, 5'd9, 32'h55);
      @(negedge clk);
      chk("clr_byp_busy_a", {31'd0, busy_a[1]}, 32'd0);
      chk("clr_nobyp_busy_b", {31'd0, busy_b[1]}, 32'd1);
      tick(); idle();
      @(negedge clk);
      chk("clr_busy_b_after", {31'd0, busy_b[0]}, 32'd0);
      tick();
      wr(0, 5'd9, 32'h66); rsv_en = 1'b1; rsv_reg = 5'd9;
      @(negedge clk);
      chk("rsvwr_busy_a_now", {31'd0, busy_a[0]}, 32'd0);
      tick(); idle();
      @(negedge clk);
      chk("rsvwr_rd_a", rd_a[31:0], 32'h66);
      chk("rsvwr_busy_a", {31'd0, busy_a[0]}, 32'd1);
      chk("rsvwr_busy_b", {31'd0, busy_b[1]}, 32'd1);
      tick();

      // dual-port writes to distinct registers
      for (int i = 0; i < 8; i++) begin
         read_reg = {5'(i + 19), 5'(i + 10)};
         wr(0, 5'(i + 10), 32'(i * 3 + 1)); wr(1, 5'(i + 20), 32'(i * 7 + 100));
         tick(); idle();
      end

      // fill, with a reset pulse that carries a write to r3
      for (int i = 1; i < 32; i++) begin
         read_reg = {5'(i - 1), 5'(i)};
         if (i == 16) begin
            reset = 1'b1; chk_on = 1'b0; wr(0, 5'd3, 32'h3333);
         end else begin
            wr(0, 5'(i), 32'(i));
         end
         tick(); idle();
         reset = 1'b0; chk_on = 1'b1;
      end
      for (int r = 0; r < 32; r++) begin
         read_reg = {5'(31 - r), 5'(r)};
         @(negedge clk);
         if (r == 3) begin
            chk("rst_mid_r3_a", rd_a[31:0], 32'd0);
            chk("rst_mid_r3_b", rd_b[31:0], 32'd0);
         end
         if (r == 20) chk("post_rst_r20_a", rd_a[31:0], 32'd20);
         tick();
      end

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
